// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry in-order FIFO between the ALU and the memory stage.
// Optional ALU_EXC_REWRITE_EN turns overflowing add/addi/sub results into exception writes.
module alu_result_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_ovf,
  input  logic [1:0]  in_op,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_exc,
  output logic [1:0]  count
);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     wr_entry;
  entry_t     head;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // reset_n is folded in so the stage refuses input while held in reset.
  assign in_ready  = reset_n && (count_q < 2'd2) && !flush;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  always_comb begin
    wr_entry.result = in_result;
    wr_entry.rd     = in_rd;
    wr_entry.exc    = 1'b0;
`ifdef ALU_EXC_REWRITE_EN
    // Overflow on add/addi/sub becomes an exception-code write to x30.
    if (in_ovf && (in_op != 2'd3)) begin
      wr_entry.result = {30'd0, in_op} + 32'd1;
      wr_entry.rd     = 5'd30;
      wr_entry.exc    = 1'b1;
    end
`endif
  end

`ifndef ALU_EXC_REWRITE_EN
  logic unused_cfg;
  assign unused_cfg = ^{in_ovf, in_op};
`endif

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage is not reset; occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  always_comb begin
    head       = mem_q[rptr_q];
    out_result = 32'd0;
    out_rd     = 5'd0;
    out_exc    = 1'b0;
    if (out_valid) begin
      out_result = head.result;
      out_rd     = head.rd;
      out_exc    = head.exc;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed pushes queue expectations, a monitor checks pops.
module tb_alu_result_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_ovf;
  logic [1:0]  in_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_exc;
  logic [1:0]  count;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  alu_result_stage dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_ovf     (in_ovf),
    .in_op      (in_op),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_exc    (out_exc),
    .count      (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic ovf, input logic [1:0] op);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_ovf    = ovf;
    in_op     = op;
  endtask

  task automatic expect_entry(input logic [31:0] res, input logic [4:0] rd, input logic exc);
    exp_t e;
    e.result = res;
    e.rd     = rd;
    e.exc    = exc;
    exp_q.push_back(e);
  endtask

  // Monitor: a pop happens at the next rising edge when these hold at the falling edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("pop_with_empty_scoreboard", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("pop_data", {26'd0, out_result, out_rd, out_exc},
            {26'd0, exp_q[0].result, exp_q[0].rd, exp_q[0].exc});
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    #12;
    chk("reset_count", {62'd0, count}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", {32'd0, out_result}, 64'd0);
    chk("reset_in_ready_low", {63'd0, in_ready}, 64'd0);
    #10;
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

    // Single push, 1-cycle latency.
    step();
    drive(1'b1, 32'h0000_00FF, 5'd5, 1'b0, 2'd0);
    expect_entry(32'h0000_00FF, 5'd5, 1'b0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    chk("single_out_valid", {63'd0, out_valid}, 64'd1);
    chk("single_out_result", {32'd0, out_result}, 64'h0000_00FF);
    chk("single_out_rd", {59'd0, out_rd}, 64'd5);
    chk("single_count", {62'd0, count}, 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drained_count", {62'd0, count}, 64'd0);
    chk("empty_out_result_zero", {32'd0, out_result}, 64'd0);

    // Fill to 2 with out_ready low; the third word is refused.
    drive(1'b1, 32'hA, 5'd1, 1'b0, 2'd0);
    expect_entry(32'hA, 5'd1, 1'b0);
    step();
    drive(1'b1, 32'hB, 5'd2, 1'b0, 2'd0);
    expect_entry(32'hB, 5'd2, 1'b0);
    step();
    drive(1'b1, 32'hC, 5'd3, 1'b0, 2'd0);
    chk("full_count", {62'd0, count}, 64'd2);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    chk("full_no_push", {62'd0, count}, 64'd2);
    out_ready = 1'b1;
    step();
    chk("full_pop_count", {62'd0, count}, 64'd1);
    step();
    out_ready = 1'b0;
    chk("full_drain_count", {62'd0, count}, 64'd0);

    // Streaming with simultaneous push/pop; rd=0 passes through unmodified.
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, i, 5'(i - 1), 1'b0, 2'd1);
      expect_entry(i, 5'(i - 1), 1'b0);
      step();
      chk("stream_count", {62'd0, count}, 64'd1);
    end
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    step();
    out_ready = 1'b0;
    chk("stream_drain_count", {62'd0, count}, 64'd0);

    // Flush at count=2 drops contents and the concurrent input.
    drive(1'b1, 32'hD, 5'd4, 1'b0, 2'd0);
    expect_entry(32'hD, 5'd4, 1'b0);
    step();
    drive(1'b1, 32'hE, 5'd6, 1'b0, 2'd0);
    expect_entry(32'hE, 5'd6, 1'b0);
    step();
    drive(1'b1, 32'hF, 5'd8, 1'b0, 2'd0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    chk("flush_count", {62'd0, count}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_result", {32'd0, out_result}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_ignores_out_ready", {62'd0, count}, 64'd0);

    // Overflow handling.
    drive(1'b1, 32'h8000_0000, 5'd7, 1'b1, 2'd2);
`ifdef ALU_EXC_REWRITE_EN
    expect_entry(32'd3, 5'd30, 1'b1);
`else
    expect_entry(32'h8000_0000, 5'd7, 1'b0);
`endif
    step();
    drive(1'b1, 32'h1234_5678, 5'd9, 1'b1, 2'd3);
    expect_entry(32'h1234_5678, 5'd9, 1'b0);
`ifdef ALU_EXC_REWRITE_EN
    chk("ovf_sub_exc", {63'd0, out_exc}, 64'd1);
`else
    chk("ovf_sub_exc", {63'd0, out_exc}, 64'd0);
`endif
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("ovf_drain_count", {62'd0, count}, 64'd0);

    // Asynchronous reset in the middle of a cycle at count=2.
    drive(1'b1, 32'h55, 5'd10, 1'b0, 2'd0);
    step();
    drive(1'b1, 32'h66, 5'd11, 1'b0, 2'd0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    chk("pre_reset_count", {62'd0, count}, 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {26'd0, out_result, out_rd, out_exc}, 64'd0);
    chk("async_reset_valid_count", {61'd0, out_valid, count}, 64'd0);
    chk("async_reset_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    #3;
    reset_n = 1'b1;
    step();
    chk("post_reset_count", {62'd0, count}, 64'd0);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Sanity transfer after reset.
    drive(1'b1, 32'hCAFE_F00D, 5'd31, 1'b0, 2'd3);
    expect_entry(32'hCAFE_F00D, 5'd31, 1'b0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
